// File: rtl/alu_pipe_pkg.sv
// Shared opcode encoding and defaults for the two-stage streaming ALU.
// The result struct is declared in alu_pipe because its width follows DATA_W.
package alu_pipe_pkg;
  localparam int          OP_W        = 4;
  localparam logic [15:0] ILL_PAT_DEF = 16'hDEAD;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_MUL = 4'd5,
    OP_SHL = 4'd6,
    OP_SHR = 4'd7,
    OP_CMP = 4'd8
  } op_e;
endpackage

// File: rtl/alu_pipe_exec.sv
// Combinational ALU datapath: opcode and operands in, result and flags out.
// Unknown opcodes produce the illegal pattern and raise err.
module alu_pipe_exec
  import alu_pipe_pkg::*;
#(
  parameter int          DATA_W  = 8,
  parameter int          RES_W   = 2*DATA_W,
  parameter logic [15:0] ILL_PAT = ILL_PAT_DEF
) (
  input  logic [OP_W-1:0]   i_opcode,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [RES_W-1:0]  o_result,
  output logic              o_carry,
  output logic              o_zero,
  output logic              o_err
);
  localparam int SH_W = $clog2(DATA_W);

  logic [DATA_W:0]   w_sum;
  logic [DATA_W-1:0] w_diff;
  logic [SH_W-1:0]   w_sh;
  logic [RES_W-1:0]  w_a_ext;
  logic [RES_W-1:0]  w_b_ext;
  logic [RES_W-1:0]  w_res;

  assign w_sum   = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff  = i_a - i_b;
  // Only the low log2(DATA_W) bits of b select the shift distance.
  assign w_sh    = i_b[SH_W-1:0];
  assign w_a_ext = RES_W'(i_a);
  assign w_b_ext = RES_W'(i_b);

  always_comb begin
    w_res   = '0;
    o_carry = 1'b0;
    o_err   = 1'b0;
    case (i_opcode)
      OP_ADD: begin
        w_res   = RES_W'(w_sum[DATA_W-1:0]);
        o_carry = w_sum[DATA_W];
      end
      OP_SUB: begin
        w_res   = RES_W'(w_diff);
        o_carry = (i_a < i_b);
      end
      OP_AND:  w_res = w_a_ext & w_b_ext;
      OP_OR:   w_res = w_a_ext | w_b_ext;
      OP_XOR:  w_res = w_a_ext ^ w_b_ext;
      OP_MUL:  w_res = w_a_ext * w_b_ext;
      OP_SHL:  w_res = w_a_ext << w_sh;
      OP_SHR:  w_res = w_a_ext >> w_sh;
      OP_CMP:  w_res = RES_W'({i_a < i_b, i_a == i_b});
      default: begin
        w_res = RES_W'(ILL_PAT);
        o_err = 1'b1;
      end
    endcase
  end

  assign o_result = w_res;
  assign o_zero   = (w_res == '0);
endmodule

// File: rtl/alu_pipe.sv
// Two-stage streaming ALU with valid/ready on both sides and tag passthrough.
// S1 registers the operation, S2 registers the computed result and flags.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter  int          DATA_W  = 8,
  parameter  int          TAG_W   = 4,
  parameter  logic [15:0] ILL_PAT = ILL_PAT_DEF,
  localparam int          RES_W   = 2*DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_opcode,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  out_result,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_carry,
  output logic              out_zero,
  output logic              out_err
);
  typedef struct packed {
    logic [RES_W-1:0] result;
    logic             carry;
    logic             zero;
    logic             err;
  } res_t;

  logic [2:1]        r_vld_pipe;
  logic [OP_W-1:0]   r_s1_op;
  logic [DATA_W-1:0] r_s1_a;
  logic [DATA_W-1:0] r_s1_b;
  logic [TAG_W-1:0]  r_s1_tag;
  logic [TAG_W-1:0]  r_s2_tag;
  res_t              r_s2_res;
  res_t              w_exec;
  logic              w_s1_adv;
  logic              w_s2_adv;

  // Each stage may drain and refill in the same cycle, so a full pipe streams.
  assign w_s2_adv = !r_vld_pipe[2] || out_ready;
  assign w_s1_adv = !r_vld_pipe[1] || w_s2_adv;
  assign in_ready = w_s1_adv;

  alu_pipe_exec #(
    .DATA_W  (DATA_W),
    .RES_W   (RES_W),
    .ILL_PAT (ILL_PAT)
  ) u_exec (
    .i_opcode (r_s1_op),
    .i_a      (r_s1_a),
    .i_b      (r_s1_b),
    .o_result (w_exec.result),
    .o_carry  (w_exec.carry),
    .o_zero   (w_exec.zero),
    .o_err    (w_exec.err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_s1_op    <= '0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_tag   <= '0;
      r_s2_tag   <= '0;
      r_s2_res   <= '0;
    end else begin
      if (w_s1_adv) begin
        r_vld_pipe[1] <= in_valid;
        if (in_valid) begin
          r_s1_op  <= in_opcode;
          r_s1_a   <= in_a;
          r_s1_b   <= in_b;
          r_s1_tag <= in_tag;
        end
      end
      // Output registers only load on a real beat so they hold while stalled.
      if (w_s2_adv) begin
        r_vld_pipe[2] <= r_vld_pipe[1];
        if (r_vld_pipe[1]) begin
          r_s2_res <= w_exec;
          r_s2_tag <= r_s1_tag;
        end
      end
    end
  end

  assign out_valid  = r_vld_pipe[2];
  assign out_result = r_s2_res.result;
  assign out_carry  = r_s2_res.carry;
  assign out_zero   = r_s2_res.zero;
  assign out_err    = r_s2_res.err;
  assign out_tag    = r_s2_tag;
endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed cases, streaming with backpressure,
// randomized traffic against an arithmetic reference model, and mid-flight reset.
module tb_alu_pipe;
  localparam int DW = 8;
  localparam int TW = 4;
  localparam int RW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_opcode;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_result;
  logic [TW-1:0] out_tag;
  logic          out_carry;
  logic          out_zero;
  logic          out_err;

  always #5 clk = ~clk;

  alu_pipe #(.DATA_W(DW), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_carry(out_carry), .out_zero(out_zero), .out_err(out_err)
  );

  typedef struct packed {
    logic [RW-1:0] res;
    logic [TW-1:0] tag;
    logic          c;
    logic          z;
    logic          e;
  } beat_t;

  beat_t exp_q[$];
  beat_t got_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    n_acc   = 0;
  int    stab_err = 0;
  beat_t w_out;
  beat_t prev_beat;
  logic  prev_stall = 1'b0;

  assign w_out = {out_result, out_tag, out_carry, out_zero, out_err};

  // Collect every accepted output beat; flag any change while stalled.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && (!out_valid || w_out !== prev_beat)) stab_err <= stab_err + 1;
      if (out_valid && out_ready) got_q.push_back(w_out);
      prev_stall <= out_valid && !out_ready;
      prev_beat  <= w_out;
    end
  end

  function automatic beat_t model(input logic [3:0] op, input logic [7:0] a,
                                  input logic [7:0] b, input logic [3:0] tag);
    int ai = a;
    int bi = b;
    int sh = b % 8;
    int r  = 0;
    beat_t m;
    m = '0;
    case (op)
      4'd0: begin r = (ai + bi) % 256; m.c = (ai + bi) > 255; end
      4'd1: begin r = (ai - bi + 256) % 256; m.c = ai < bi; end
      4'd2: r = ai & bi;
      4'd3: r = ai | bi;
      4'd4: r = ai ^ bi;
      4'd5: r = ai * bi;
      4'd6: r = ai * (1 << sh);
      4'd7: r = ai / (1 << sh);
      4'd8: r = (ai < bi ? 2 : 0) + (ai == bi ? 1 : 0);
      default: begin r = 'hDEAD; m.e = 1'b1; end
    endcase
    m.res = 16'(r);
    m.tag = tag;
    m.z   = (r == 0);
    return m;
  endfunction

  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [3:0] tag, output bit tmo);
    tmo = 1'b1;
    in_valid = 1'b1; in_opcode = op; in_a = a; in_b = b; in_tag = tag;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(op, a, b, tag));
        n_acc++;
        @(posedge clk); #1;
        tmo = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic drain(output bit tmo);
    in_valid = 1'b0; out_ready = 1'b1; tmo = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (got_q.size() >= exp_q.size()) begin tmo = 1'b0; break; end
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic one_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] tag, output beat_t g, output bit tmo);
    bit t1, t2;
    send(op, a, b, tag, t1);
    drain(t2);
    g = '0;
    tmo = t1 || t2 || (got_q.size() != 1);
    if (got_q.size() > 0) g = got_q.pop_front();
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_opcode = '0; in_a = '0; in_b = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_tests++;
    if (w_out !== '0) begin n_fail++; $display("FAIL reset_outputs got %h want 0", w_out); end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    beat_t g, e;
    bit t;
    // ADD overflow with latency probe
    out_ready = 1'b1;
    send(4'd0, 8'hFF, 8'h01, 4'h3, t);
    in_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (t || out_valid !== 1'b0) begin n_fail++; $display("FAIL add_latency_early got %b want 0 tmo %0d", out_valid, t); end
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_latency got %b want 1", out_valid); end
    drain(t);
    e = {16'h0000, 4'h3, 1'b1, 1'b1, 1'b0};
    g = (got_q.size() > 0) ? got_q[0] : '0;
    n_tests++;
    if (t || got_q.size() != 1 || g !== e) begin n_fail++; $display("FAIL add_ovf got %h want %h", g, e); end
    exp_q.delete(); got_q.delete();

    one_op(4'd1, 8'd3, 8'd5, 4'h1, g, t);
    e = {16'h00FE, 4'h1, 1'b1, 1'b0, 1'b0};
    n_tests++;
    if (t || g !== e) begin n_fail++; $display("FAIL sub_borrow got %h want %h", g, e); end

    one_op(4'd5, 8'hFF, 8'hFF, 4'h2, g, t);
    e = {16'hFE01, 4'h2, 1'b0, 1'b0, 1'b0};
    n_tests++;
    if (t || g !== e) begin n_fail++; $display("FAIL mul_full got %h want %h", g, e); end

    one_op(4'hC, 8'h12, 8'h34, 4'h7, g, t);
    e = {16'hDEAD, 4'h7, 1'b0, 1'b0, 1'b1};
    n_tests++;
    if (t || g !== e) begin n_fail++; $display("FAIL illegal_op got %h want %h", g, e); end

    one_op(4'd2, 8'hF0, 8'h0F, 4'h8, g, t);
    e = {16'h0000, 4'h8, 1'b0, 1'b1, 1'b0};
    n_tests++;
    if (t || g !== e) begin n_fail++; $display("FAIL after_illegal_and got %h want %h", g, e); end

    one_op(4'd6, 8'h81, 8'hF9, 4'h9, g, t);
    e = {16'h0102, 4'h9, 1'b0, 1'b0, 1'b0};
    n_tests++;
    if (t || g !== e) begin n_fail++; $display("FAIL shl_mask got %h want %h", g, e); end

    one_op(4'd7, 8'h80, 8'h0F, 4'hA, g, t);
    e = {16'h0001, 4'hA, 1'b0, 1'b0, 1'b0};
    n_tests++;
    if (t || g !== e) begin n_fail++; $display("FAIL shr_max got %h want %h", g, e); end

    one_op(4'd8, 8'd4, 8'd4, 4'hB, g, t);
    e = {16'h0001, 4'hB, 1'b0, 1'b0, 1'b0};
    n_tests++;
    if (t || g !== e) begin n_fail++; $display("FAIL cmp_eq got %h want %h", g, e); end
  endtask

  task automatic test_back_to_back;
    bit tmo_any = 1'b0;
    bit drop_seen = 1'b0;
    int acc0 = 0;
    int acc_drop = 0;
    bit t;
    beat_t g, e;
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send(4'($urandom_range(9)), 8'($urandom), 8'($urandom), 4'(i), t);
          tmo_any |= t;
        end
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        acc0 = n_acc;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          if (!in_ready && !drop_seen) begin drop_seen = 1'b1; acc_drop = n_acc; end
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    n_tests++;
    if (!drop_seen || acc_drop - acc0 > 2) begin
      n_fail++; $display("FAIL b2b_in_ready_drop seen %0d accepts %0d want seen within 2", drop_seen, acc_drop - acc0);
    end
    drain(t);
    n_tests++;
    if (t || tmo_any || got_q.size() != 8 || exp_q.size() != 8) begin
      n_fail++; $display("FAIL b2b_count got %0d want 8 (sent %0d)", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_tests++;
      if (g !== e) begin n_fail++; $display("FAIL b2b_beat got %h want %h", g, e); end
    end
    n_tests++;
    if (stab_err != 0) begin n_fail++; $display("FAIL stall_stable got %0d changes want 0", stab_err); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_random;
    bit done = 1'b0;
    bit tmo_any = 1'b0;
    bit t;
    int n_sent;
    beat_t g, e;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          if ($urandom_range(3) == 0) begin in_valid = 1'b0; @(posedge clk); #1; end
          send(($urandom_range(4) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(8)),
               8'($urandom), 8'($urandom), 4'($urandom), t);
          tmo_any |= t;
        end
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(2) != 0);
          @(posedge clk); #1;
        end
      end
    join
    drain(t);
    n_sent = exp_q.size();
    n_tests++;
    if (t || tmo_any || got_q.size() != n_sent || n_sent != 40) begin
      n_fail++; $display("FAIL rand_count got %0d want %0d", got_q.size(), n_sent);
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_tests++;
      if (g !== e) begin n_fail++; $display("FAIL rand_beat got %h want %h", g, e); end
    end
    n_tests++;
    if (stab_err != 0) begin n_fail++; $display("FAIL rand_stall_stable got %0d changes want 0", stab_err); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_mid_reset;
    bit t1, t2;
    beat_t g, e;
    out_ready = 1'b0;
    send(4'd0, 8'd10, 8'd20, 4'h4, t1);
    send(4'd3, 8'h0F, 8'hF0, 4'h5, t2);
    in_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (t1 || t2 || out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_inflight got %b want 1", out_valid); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || w_out !== '0) begin
      n_fail++; $display("FAIL midrst_clear got valid %b out %h want 0", out_valid, w_out);
    end
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n_tests++;
    if (got_q.size() != 0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_stale got %0d beats want 0", got_q.size());
    end
    got_q.delete();
    one_op(4'd0, 8'd1, 8'd2, 4'h6, g, t1);
    e = {16'h0003, 4'h6, 1'b0, 1'b0, 1'b0};
    n_tests++;
    if (t1 || g !== e) begin n_fail++; $display("FAIL midrst_recover got %h want %h", g, e); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
